// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial unsigned subtractor, diff = a - b mod 2^WIDTH.
// One full-subtractor cell plus a borrow flop. Bits are processed LSB-first, one per clock.
// A start/done handshake brackets each operation.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int            CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] sd;
    logic             br;
    logic [CW-1:0]    cnt;

    // Full-subtractor cell acting on the current LSBs and the stored borrow.
    logic             x;
    logic             y;
    logic             d;
    logic             br_next;
    logic [WIDTH-1:0] sd_next;

    // Compute the difference bit for this cycle, the next borrow, and the next result-register value.
    always_comb begin
        x       = sa[0];
        y       = sb[0];
        d       = x ^ y ^ br;
        br_next = (~x & y) | (~(x ^ y) & br);
        sd_next = {d, sd[WIDTH-1:1]};
    end

    // Control FSM and datapath. All outputs are registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            sa     <= '0;
            sb     <= '0;
            sd     <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            diff   <= '0;
            borrow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        sa    <= a;
                        sb    <= b;
                        sd    <= '0;
                        br    <= 1'b0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    // start is ignored while the operation is in progress.
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    sd  <= sd_next;
                    br  <= br_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        // Publish the result, including the bit computed on this edge.
                        diff   <= sd_next;
                        borrow <= br_next;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        done <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed and random checks of serial_subtractor at WIDTH=8 and WIDTH=3.
module tb_serial_subtractor;

    logic       clk;
    logic       rst;
    logic       start8, start3;
    logic [7:0] a8, b8;
    logic [2:0] a3, b3;
    logic       busy8, done8, borrow8;
    logic       busy3, done3, borrow3;
    logic [7:0] diff8;
    logic [2:0] diff3;

    int tests;
    int fails;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8)
    );

    serial_subtractor #(.WIDTH(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .a(a3), .b(b3),
        .busy(busy3), .done(done3), .diff(diff3), .borrow(borrow3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference result: {a < b, (a - b) mod 2^w}, from plain integer arithmetic.
    function automatic int model(input int av, input int bv, input int w);
        int m;
        m = ((av - bv) % (1 << w) + (1 << w)) % (1 << w);
        return ((av < bv) ? (1 << w) : 0) + m;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // A single WIDTH=8 operation with a one-cycle start pulse, checking latency, busy and the result.
    task automatic op8(input int av, input int bv, input string tag);
        int n;
        int busy_cnt;
        chk({tag, ":idle"}, int'(busy8), 0);
        a8 = 8'(av); b8 = 8'(bv); start8 = 1'b1;
        tick();
        start8 = 1'b0;
        n = 0; busy_cnt = 0;
        while (!done8 && n < 20) begin
            if (busy8) busy_cnt++;
            tick();
            n++;
        end
        chk({tag, ":latency"}, n, 8);
        chk({tag, ":busy_cycles"}, busy_cnt, 8);
        chk({tag, ":result"}, {23'd0, borrow8, diff8}, model(av, bv, 8));
        tick();
        chk({tag, ":done_drop"}, int'(done8), 0);
    endtask

    // A single WIDTH=3 operation.
    task automatic op3(input int av, input int bv, input string tag);
        int n;
        a3 = 3'(av); b3 = 3'(bv); start3 = 1'b1;
        tick();
        start3 = 1'b0;
        n = 0;
        while (!done3 && n < 10) begin
            tick();
            n++;
        end
        chk({tag, ":latency"}, n, 3);
        chk({tag, ":result"}, {28'd0, borrow3, diff3}, model(av, bv, 3));
    endtask

    initial begin
        int n;
        int dcount;
        tests = 0; fails = 0;
        rst = 1'b1; start8 = 1'b0; start3 = 1'b0;
        a8 = '0; b8 = '0; a3 = '0; b3 = '0;

        // Reset state
        #2;
        chk("reset8", {20'd0, busy8, done8, borrow8, diff8}, 0);
        chk("reset3", {25'd0, busy3, done3, borrow3, diff3}, 0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // Basic operation: 9 - 1
        op8(9, 1, "basic");

        // Back-to-back with start held high
        a8 = 8'd15; b8 = 8'd0; start8 = 1'b1;
        tick();
        a8 = 8'd12; b8 = 8'd2;
        n = 0;
        while (!done8 && n < 20) begin tick(); n++; end
        chk("b2b_first_latency", n, 8);
        chk("b2b_first", {23'd0, borrow8, diff8}, model(15, 0, 8));
        n = 0;
        tick(); n++;
        while (!done8 && n < 20) begin tick(); n++; end
        start8 = 1'b0;
        chk("b2b_spacing", n, 9);
        chk("b2b_second", {23'd0, borrow8, diff8}, model(12, 2, 8));
        tick();

        // Borrow cases
        op8(5, 10, "borrow_5_10");
        op8(0, 1, "borrow_0_1");
        op8(8'hAA, 8'hAA, "equal");

        // start while busy is ignored
        a8 = 8'h10; b8 = 8'h01; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick(); tick();
        a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        dcount = 0;
        for (int i = 0; i < 16; i++) begin
            if (done8) begin
                dcount++;
                chk("busy_ignore_result", {23'd0, borrow8, diff8}, 9'h00F);
            end
            tick();
        end
        chk("busy_ignore_done_count", dcount, 1);

        // Reset in the middle of an operation
        a8 = 8'd200; b8 = 8'd7; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick(); tick(); tick();
        #2 rst = 1'b1;
        #1;
        chk("midreset_outputs", {20'd0, busy8, done8, borrow8, diff8}, 0);
        tick();
        rst = 1'b0;
        dcount = 0;
        for (int i = 0; i < 14; i++) begin
            if (done8) dcount++;
            tick();
        end
        chk("midreset_no_done", dcount, 0);
        op8(3, 2, "after_reset");

        // Random sweep, WIDTH=8
        for (int i = 0; i < 1000; i++) begin
            op8(int'($urandom_range(255)), int'($urandom_range(255)), "rand8");
        end

        // Random sweep and corners, WIDTH=3
        op3(0, 7, "w3_corner_0_7");
        op3(7, 0, "w3_corner_7_0");
        for (int i = 0; i < 200; i++) begin
            op3(int'($urandom_range(7)), int'($urandom_range(7)), "rand3");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial N-bit subtractor computing `diff = a - b` LSB-first through a single full-subtractor cell and a borrow flip-flop. It is the inverse counterpart of the team's half/full adder arithmetic blocks. It trades area for latency: one result bit is produced per clock. It sits beside the adder cells in the arithmetic library and is driven by a start/done handshake from a controlling FSM or testbench.

## Interface
- `WIDTH`, default 8: operand and result width in bits (≥ 2).
- `clk`  in  1: rising-edge clock.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: request. Sampled on a rising edge; accepted only in IDLE.
- `a`  in  WIDTH: minuend, unsigned. Captured on the accepting edge only.
- `b`  in  WIDTH: subtrahend, unsigned. Captured on the accepting edge only.
- `busy`  out  1: high while an operation is in progress (state SHIFT).
- `done`  out  1: one-cycle pulse; `diff` and `borrow` are valid from this cycle onward.
- `diff`  out  WIDTH: result `(a - b) mod 2^WIDTH`. Holds until the next completion.
- `borrow`  out  1: final borrow-out; 1 iff `a < b`. Holds with `diff`.

## Operation
- Internal state:
  - FSM `{IDLE, SHIFT}`.
  - Operand shift registers `sa`, `sb` (WIDTH bits each).
  - Result shift register `sd` (WIDTH bits).
  - Borrow flip-flop `br`.
  - Bit counter `cnt`, width `$clog2(WIDTH+1)`.
- IDLE and `start`=1 on an edge:
  - `sa`←`a`, `sb`←`b`, `br`←0, `cnt`←0, `sd`←0.
  - Go to SHIFT.
- SHIFT, on every edge, with `x=sa[0]`, `y=sb[0]`:
  - `d = x ^ y ^ br`.
  - `br ← (~x & y) | (~(x ^ y) & br)`.
  - `sd ← {d, sd[WIDTH-1:1]}` (result enters at the MSB and shifts right).
  - `sa`, `sb` shift right by 1; `cnt ← cnt+1`.
- When the edge processes bit WIDTH-1 (`cnt == WIDTH-1` before the edge):
  - `diff ←` the final `sd` value (including the bit just computed).
  - `borrow ←` the final `br`.
  - `done ← 1`; go to IDLE.
- On every other edge, `done ← 0`.
- `start` while in SHIFT is ignored. There is no queuing, and `a`/`b` changes have no effect.
- `start` in the same cycle `done`=1 is accepted, because the FSM is already in IDLE.
- Arithmetic is unsigned modulo 2^WIDTH. A two's-complement interpretation of `diff` is the caller's concern.

## Timing
- Reset (asynchronous, immediate): state=IDLE, `busy`=0, `done`=0, `diff`=0, `borrow`=0, all internal registers 0.
- Reset mid-operation aborts the operation. No `done` is produced and the previous `diff`/`borrow` are lost (set to 0).
- Accept edge T0: `busy`=1 after T0.
- Bits are processed on edges T1..T_WIDTH.
- After edge T_WIDTH: `busy`=0, `done`=1, `diff`/`borrow` updated. Latency is WIDTH cycles from accept to `done`.
- After edge T_WIDTH+1: `done`=0.
- Back-to-back throughput: one operation per WIDTH+1 cycles when `start` is held high continuously.
- All outputs are registered. No combinational path from inputs to outputs.

## Test plan
- WIDTH=8: `a`=9, `b`=1, one-cycle `start`:
  - `done` pulses exactly 8 cycles after accept.
  - `diff`=8, `borrow`=0.
  - `busy` is high for exactly 8 cycles.
- Back-to-back, `start` held high:
  - First `a`=15, `b`=0 → `diff`=15, `borrow`=0.
  - Second `a`=12, `b`=2 → `diff`=10, `borrow`=0.
  - Second `done` occurs 9 cycles after the first.
- Borrow cases:
  - `a`=5, `b`=10 → `diff`=0xFB, `borrow`=1.
  - `a`=0, `b`=1 → `diff`=0xFF, `borrow`=1.
  - `a`=0xAA, `b`=0xAA → `diff`=0, `borrow`=0.
- Busy-ignore: start `a`=0x10, `b`=0x01. Three cycles later, pulse `start` with `a`=0xFF, `b`=0xFF.
  - Result is `diff`=0x0F, `borrow`=0.
  - Exactly one `done` pulse.
- Reset mid-op: assert `rst` asynchronously (between edges) 4 cycles into an operation.
  - Outputs go to 0 immediately.
  - No `done` pulse follows.
  - A new `start` after release (`a`=3, `b`=2) gives `diff`=1, `borrow`=0.
- Random sweep: 1000 random `a`/`b` at WIDTH=8 plus a WIDTH=3 build.
  - `{borrow, diff}` matches the reference model `{a < b, (a - b) mod 2^WIDTH}` on every `done`.
